// File: rtl/rng_arbiter.sv
// Round-robin arbiter handing out values from a shared 32-bit LFSR, with a
// cool-down gap between values and a prioritised reseed path.
module rng_arbiter #(
   parameter int N_REQ = 4,
   parameter int GAP   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [31:0]      rnd_o,
   input  logic             seed_req_i,
   input  logic [31:0]      seed_i,
   output logic             seed_ack_o,
   input  logic [31:0]      lfsr_random_i,
   output logic [31:0]      lfsr_seed_o,
   output logic             lfsr_seed_v_o,
   output logic             busy_o
);

   localparam int PW = $clog2(N_REQ);

   typedef enum logic [1:0] {IDLE, SEED, COOL} state_t;

   state_t           state, state_n;
   logic [PW-1:0]    ptr, ptr_n;
   logic [3:0]       cnt, cnt_n;
   logic [N_REQ-1:0] gnt_n;
   logic [31:0]      rnd_n;
   logic [31:0]      seed_n;
   logic             seed_v_n;
   logic             found;
   logic [PW-1:0]    winner;

   // Search upward from the pointer with wrap; the first set request wins.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && req_i[(int'(ptr) + i) % N_REQ]) begin
            found  = 1'b1;
            winner = PW'((int'(ptr) + i) % N_REQ);
         end
      end
   end

   always_comb begin
      state_n  = state;
      ptr_n    = ptr;
      cnt_n    = cnt;
      gnt_n    = '0;
      rnd_n    = rnd_o;
      seed_n   = lfsr_seed_o;
      seed_v_n = 1'b0;
      case (state)
         IDLE: begin
            if (seed_req_i) begin
               // An all-zero LFSR never leaves zero, so a zero seed is replaced.
               seed_n   = (seed_i == 32'd0) ? 32'h0000_0001 : seed_i;
               seed_v_n = 1'b1;
               state_n  = SEED;
            end else if (found) begin
               gnt_n = N_REQ'(1) << winner;
               rnd_n = lfsr_random_i;
               ptr_n = (winner == PW'(N_REQ - 1)) ? '0 : winner + PW'(1);
               if (GAP > 1) begin
                  state_n = COOL;
                  cnt_n   = 4'(GAP - 1);
               end
            end
         end
         SEED: begin
            state_n = COOL;
            cnt_n   = 4'(GAP);
         end
         COOL: begin
            if (cnt <= 4'd1) begin
               cnt_n   = '0;
               state_n = IDLE;
            end else begin
               cnt_n = cnt - 4'd1;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         ptr           <= '0;
         cnt           <= '0;
         gnt_o         <= '0;
         rnd_o         <= '0;
         lfsr_seed_o   <= '0;
         lfsr_seed_v_o <= 1'b0;
      end else begin
         state         <= state_n;
         ptr           <= ptr_n;
         cnt           <= cnt_n;
         gnt_o         <= gnt_n;
         rnd_o         <= rnd_n;
         lfsr_seed_o   <= seed_n;
         lfsr_seed_v_o <= seed_v_n;
      end
   end

   assign seed_ack_o = lfsr_seed_v_o;
   assign busy_o     = (state != IDLE);

endmodule

// File: tb/tb_rng_arbiter.sv
// Bench for rng_arbiter: three instances (GAP 2, 1, 4) share reset, seed and LFSR
// inputs; expected grants are queued ahead and compared every cycle.
module tb_rng_arbiter;

   typedef struct {
      int         dut;
      int         cyc;
      logic [3:0] gnt;
      logic [31:0] rnd;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, seedReq;
   logic [31:0] seed, lfsr;
   logic [3:0]  reqA, reqB, reqC;
   logic [3:0]  gntA, gntB, gntC;
   logic [31:0] rndA, rndB, rndC;
   logic [31:0] lfsrSeedA, lfsrSeedB, lfsrSeedC;
   logic        seedAckA, seedAckB, seedAckC;
   logic        seedVA, seedVB, seedVC;
   logic        busyA, busyB, busyC;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          c, s;
   exp_t        sb[$];
   logic [31:0] lastRnd[3];
   int          seedCycA = -1;
   logic [31:0] pendingSeed, lastSeedA;

   always #5 clk = ~clk;

   rng_arbiter #(.N_REQ(4), .GAP(2)) dutA (
      .clk(clk), .rst(rst), .req_i(reqA), .gnt_o(gntA), .rnd_o(rndA),
      .seed_req_i(seedReq), .seed_i(seed), .seed_ack_o(seedAckA),
      .lfsr_random_i(lfsr), .lfsr_seed_o(lfsrSeedA), .lfsr_seed_v_o(seedVA),
      .busy_o(busyA));

   rng_arbiter #(.N_REQ(4), .GAP(1)) dutB (
      .clk(clk), .rst(rst), .req_i(reqB), .gnt_o(gntB), .rnd_o(rndB),
      .seed_req_i(seedReq), .seed_i(seed), .seed_ack_o(seedAckB),
      .lfsr_random_i(lfsr), .lfsr_seed_o(lfsrSeedB), .lfsr_seed_v_o(seedVB),
      .busy_o(busyB));

   rng_arbiter #(.N_REQ(4), .GAP(4)) dutC (
      .clk(clk), .rst(rst), .req_i(reqC), .gnt_o(gntC), .rnd_o(rndC),
      .seed_req_i(seedReq), .seed_i(seed), .seed_ack_o(seedAckC),
      .lfsr_random_i(lfsr), .lfsr_seed_o(lfsrSeedC), .lfsr_seed_v_o(seedVC),
      .busy_o(busyC));

   // The LFSR input follows a known function of the edge number.
   function automatic logic [31:0] lfsrAt(input int k);
      return 32'hA5A5_0000 + 32'(k);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic expectGrant(input int dut, input int at, input logic [3:0] g);
      exp_t e;
      e.dut = dut;
      e.cyc = at;
      e.gnt = g;
      e.rnd = lfsrAt(at);
      sb.push_back(e);
   endtask

   // One clock: compare grant/value outputs of every instance and the seed outputs of dutA.
   task automatic applyStimulus();
      logic        rstEdge;
      logic [3:0]  g[3];
      logic [31:0] r[3];
      logic [3:0]  eg;
      logic [31:0] er;
      exp_t        keep[$];
      rstEdge = rst;
      @(posedge clk);
      cyc++;
      #1;
      g[0] = gntA; g[1] = gntB; g[2] = gntC;
      r[0] = rndA; r[1] = rndB; r[2] = rndC;
      for (int k = 0; k < 3; k++) begin
         eg = 4'd0;
         er = rstEdge ? 32'd0 : lastRnd[k];
         foreach (sb[i]) begin
            if (sb[i].dut == k && sb[i].cyc == cyc) begin
               eg = sb[i].gnt;
               er = sb[i].rnd;
            end
         end
         checkOutput($sformatf("gnt%0d@%0d", k, cyc), 32'(g[k]), 32'(eg));
         checkOutput($sformatf("rnd%0d@%0d", k, cyc), r[k], er);
         lastRnd[k] = er;
      end
      foreach (sb[i]) if (sb[i].cyc > cyc) keep.push_back(sb[i]);
      sb = keep;
      if (cyc == seedCycA) lastSeedA = pendingSeed;
      if (rstEdge) lastSeedA = 32'd0;
      checkOutput($sformatf("seedV@%0d", cyc), 32'(seedVA), 32'(cyc == seedCycA && !rstEdge));
      checkOutput($sformatf("seedAck@%0d", cyc), 32'(seedAckA), 32'(cyc == seedCycA && !rstEdge));
      checkOutput($sformatf("lfsrSeed@%0d", cyc), lfsrSeedA, lastSeedA);
      lfsr = lfsrAt(cyc + 1);
   endtask

   initial begin
      rst = 1'b1; seedReq = 1'b0; seed = 32'd0;
      reqA = 4'd0; reqB = 4'd0; reqC = 4'd0;
      lfsr = lfsrAt(1);
      lastSeedA = 32'd0; pendingSeed = 32'd0;
      for (int k = 0; k < 3; k++) lastRnd[k] = 32'd0;

      // Reset state
      applyStimulus(); applyStimulus();
      checkOutput("busyA_rst", 32'(busyA), 32'd0);
      checkOutput("busyB_rst", 32'(busyB), 32'd0);
      checkOutput("busyC_rst", 32'(busyC), 32'd0);

      // GAP=2, single requester held: grants every other cycle
      rst = 1'b0; reqA = 4'b0001; c = cyc;
      expectGrant(0, c + 1, 4'b0001);
      expectGrant(0, c + 3, 4'b0001);
      expectGrant(0, c + 5, 4'b0001);
      applyStimulus();
      checkOutput("busyA_cool", 32'(busyA), 32'd1);
      applyStimulus();
      checkOutput("busyA_idle", 32'(busyA), 32'd0);
      repeat (3) applyStimulus();
      // Request raised during cool-down and dropped before the decision edge
      reqA = 4'b0100;
      applyStimulus();
      reqA = 4'b0000;
      repeat (2) applyStimulus();

      // GAP=1, all requesting from reset: one grant per cycle in rotation
      rst = 1'b1; reqB = 4'b1111;
      applyStimulus();
      rst = 1'b0; c = cyc;
      expectGrant(1, c + 1, 4'b0001);
      expectGrant(1, c + 2, 4'b0010);
      expectGrant(1, c + 3, 4'b0100);
      expectGrant(1, c + 4, 4'b1000);
      expectGrant(1, c + 5, 4'b0001);
      repeat (5) applyStimulus();
      reqB = 4'b0000;
      applyStimulus();

      // Reseed and request at the same edge: reseed first, grant GAP+2 cycles later
      c = cyc;
      reqA = 4'b0010; seedReq = 1'b1; seed = 32'h1234_5678;
      seedCycA = c + 1; pendingSeed = 32'h1234_5678;
      expectGrant(0, c + 5, 4'b0010);
      applyStimulus();
      seedReq = 1'b0;
      checkOutput("busyA_seed", 32'(busyA), 32'd1);
      repeat (4) applyStimulus();
      reqA = 4'b0000;
      applyStimulus();

      // Zero seed is replaced by 1; pointer (now 2) survives the reseed
      seedReq = 1'b1; seed = 32'd0;
      seedCycA = cyc + 1; pendingSeed = 32'h0000_0001;
      applyStimulus();
      s = cyc;
      seedReq = 1'b0; reqA = 4'b1111;
      expectGrant(0, s + 4, 4'b0100);
      repeat (4) applyStimulus();

      // Pointer wrap from 3 to 0
      reqA = 4'b1001;
      expectGrant(0, s + 6, 4'b1000);
      expectGrant(0, s + 8, 4'b0001);
      repeat (4) applyStimulus();
      reqA = 4'b0000;
      repeat (2) applyStimulus();

      // GAP=4: reset during cool-down aborts it and clears the pointer
      c = cyc; reqC = 4'b0001;
      expectGrant(2, c + 1, 4'b0001);
      applyStimulus();
      applyStimulus();
      rst = 1'b1; reqC = 4'b1111;
      applyStimulus();
      checkOutput("busyC_abort", 32'(busyC), 32'd0);
      checkOutput("seedAckC_abort", 32'(seedAckC), 32'd0);
      checkOutput("seedVC_abort", 32'(seedVC), 32'd0);
      checkOutput("lfsrSeedC_abort", lfsrSeedC, 32'd0);
      rst = 1'b0;
      expectGrant(2, cyc + 1, 4'b0001);
      applyStimulus();
      reqC = 4'b0000;
      repeat (2) applyStimulus();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rng_arbiter.md
RNG_ARBITER -- requirements
Module: rng_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, legal range 2..8.
REQ-002 Parameter GAP, default 2: minimum number of LFSR steps between values handed out, legal range 1..15.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_i  input  N_REQ  per-requester request level.
REQ-006 gnt_o  output  N_REQ  one-hot grant pulse; high for one cycle, coincident with valid rnd_o.
REQ-007 rnd_o  output  32  random value for the granted requester; holds its last value otherwise.
REQ-008 seed_req_i  input  1  reseed request level.
REQ-009 seed_i  input  32  seed value, sampled when the reseed is accepted.
REQ-010 seed_ack_o  output  1  one-cycle pulse when the reseed is issued.
REQ-011 lfsr_random_i  input  32  current state of the shared 32-bit LFSR.
REQ-012 lfsr_seed_o  output  32  seed value driven to the LFSR.
REQ-013 lfsr_seed_v_o  output  1  one-cycle LFSR load strobe.
REQ-014 busy_o  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 The FSM shall have exactly three states: IDLE, SEED and COOL.
REQ-016 IDLE decision edge, reseed case: if seed_req_i=1, the arbiter shall take the reseed; reseed has priority over all req_i.
REQ-017 IDLE decision edge, grant case: if seed_req_i=0 and any req_i bit is set, the arbiter shall pick one winner by round robin.
REQ-018 Round robin shall search upward from the pointer, wrapping N_REQ-1 to 0; the first set bit wins; the pointer then becomes (winner+1) mod N_REQ.
REQ-019 Grant latency shall be 1 cycle: req seen at decision edge t gives gnt_o[winner]=1 and rnd_o=lfsr_random_i (as sampled at t) during cycle t+1.
REQ-020 After a grant: if GAP=1, the FSM shall stay in IDLE (one grant per cycle possible); if GAP>1, it shall enter COOL with cnt=GAP-1.
REQ-021 COOL shall decrement cnt each cycle and return to IDLE on the edge where cnt reaches 0; req_i and seed_req_i shall be ignored while in COOL.
REQ-022 req_i shall be sampled only at IDLE decision edges; a bit held high through its grant cycle shall count as a new request.
REQ-023 A requester dropping req_i before its decision edge shall not be granted, and no stale grant shall be issued.
REQ-024 Reseed issue: at the accepting edge, lfsr_seed_o shall load seed_i (or 32'h00000001 if seed_i=0, since an all-zero LFSR locks up) and FSM shall enter SEED.
REQ-025 SEED shall last exactly 1 cycle, with lfsr_seed_v_o=1 and seed_ack_o=1; the FSM then enters COOL with cnt=GAP.
REQ-026 Consequently, the first value granted after a reseed shall be the seed advanced by at least GAP LFSR steps.
REQ-027 The reseed shall not move the round-robin pointer.
REQ-028 gnt_o shall never have more than one bit set, and shall never be set in the same cycle as lfsr_seed_v_o.
REQ-029 lfsr_seed_o shall hold its value between reseeds.
REQ-030 Outside grant and SEED cycles, gnt_o, seed_ack_o and lfsr_seed_v_o shall be 0.

Reset
REQ-031 When rst=1 at an edge, the following shall be set: state=IDLE; pointer=0; cnt=0; gnt_o=0; rnd_o=0; seed_ack_o=0; lfsr_seed_o=0; lfsr_seed_v_o=0; busy_o=0.
REQ-032 Reset asserted mid-COOL or mid-SEED shall abort the operation with no further grant or strobe, overriding every other condition.
REQ-033 The first decision edge shall be the first edge with rst=0.

Verification
REQ-034 GAP=2, req_i=4'b0001 held, lfsr_random_i=32'hA5A5_0001 -> gnt_o=0001 with rnd_o=A5A5_0001 one cycle later; grants repeat every 2 cycles.
REQ-035 GAP=1, req_i=4'b1111 held from reset -> gnt_o sequence 0001,0010,0100,1000,0001 on consecutive cycles.
REQ-036 seed_req_i=1 and req_i=4'b0010 at the same IDLE edge, seed_i=32'h1234_5678 -> next cycle lfsr_seed_v_o=1, seed_ack_o=1, lfsr_seed_o=1234_5678, gnt_o=0; the requester 1 grant arrives exactly GAP+2 cycles after acceptance.
REQ-037 seed_i=0 reseed -> lfsr_seed_o=32'h0000_0001 during the SEED cycle.
REQ-038 GAP=4, grant issued, rst=1 two cycles later -> all outputs 0, busy_o=0, pointer=0; a request in the first post-reset cycle is granted to index 0 if req_i[0]=1.
REQ-039 Pointer wrap: pointer=3, req_i=4'b1001 -> requester 3 granted, then requester 0.
